mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max BUSY cycles waiting for m_ready before abort (1..255).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports if_req (in, 1) and if_addr (in, 32): instruction-fetch request and byte address.
REQ-005 SHALL have ports if_gnt, if_valid, if_err (out, 1 each) and if_rdata (out, 32): fetch accept pulse, response pulse, error, word.
REQ-006 SHALL have ports d_req, d_we, d_signed (in, 1 each), d_size (in, 2; 00 byte, 01 half, 10 word, 11 illegal), d_addr and d_wdata (in, 32): data request.
REQ-007 SHALL have ports d_gnt, d_valid, d_err (out, 1 each) and d_rdata (out, 32): data accept pulse, response pulse, error, load result.
REQ-008 SHALL have memory ports m_en, m_we (out, 1), m_addr (out, 30, word address), m_be (out, 4), m_wdata (out, 32), m_rdata (in, 32), m_ready (in, 1).

Function
REQ-009 SHALL implement FSM IDLE, BUSY, RESP; transitions: IDLE->BUSY on accepted legal request; IDLE->RESP on accepted illegal request; BUSY->RESP on m_ready or timeout; RESP->IDLE always.
REQ-010 SHALL sample requests in IDLE only; requests arriving in BUSY/RESP wait; requester holds req until its gnt.
REQ-011 SHALL, when both request in IDLE, grant round-robin: requester not granted last wins; single requester always wins.
REQ-012 SHALL pulse the winner's gnt for exactly one cycle, the first BUSY (or RESP) cycle, and latch addr/size/we/signed/wdata at acceptance.
REQ-013 SHALL hold m_en=1 and m_addr, m_we, m_be, m_wdata stable for every BUSY cycle; all m_* outputs 0 outside BUSY.
REQ-014 SHALL use little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]; m_addr = addr[31:2].
REQ-015 SHALL drive m_be: word 1111; half 0011 (addr[1]=0) or 1100; byte 0001<<addr[1:0]; fetch always 1111, m_we=0.
REQ-016 SHALL replicate store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-017 SHALL right-align load data from the selected lane, sign-extend if d_signed else zero-extend; capture at the m_ready cycle.
REQ-018 SHALL treat as illegal: d_size=11, half with addr[0]=1, word with addr[1:0]!=00, fetch with addr[1:0]!=00; illegal requests skip memory and respond with err=1.
REQ-019 SHALL count BUSY cycles; if m_ready is not seen in TIMEOUT cycles, enter RESP with err=1 and rdata=0; late m_ready ignored.
REQ-020 SHALL pulse the owner's valid for exactly one cycle in RESP, with rdata/err valid only then; stores return rdata=0.
REQ-021 SHALL ignore req deassertion after gnt; the transaction completes.
REQ-022 SHALL tolerate m_ready high in the first BUSY cycle (single-cycle memory): total latency req-to-valid = 3 cycles.

Reset
REQ-023 SHALL, on reset low, immediately force IDLE, all outputs 0, timeout counter 0, round-robin pointer "last=data" (fetch wins the first tie).
REQ-024 SHALL abandon any in-flight transaction on reset without valid pulse; m_en drops asynchronously.

Structure
REQ-025 SHALL place state encoding, d_size codes and requester IDs in shared package mem_arb_pkg.
REQ-026 SHALL implement lane steering and extension (REQ-015..017) in one combinational sub-module mem_lane_align.

Verification
REQ-027 SHALL test load byte: d_addr=0x102, size=00, signed=1, m_rdata=0x11802233 -> m_addr=0x40, m_be=0100, d_rdata=0xFFFFFF80, d_valid 1 cycle.
REQ-028 SHALL test store half: d_addr=0x206, size=01, d_wdata=0x0000ABCD -> m_be=1100, m_wdata=0xABCDABCD, m_we=1, d_valid with d_rdata=0.
REQ-029 SHALL test contention: if_req and d_req high in the same IDLE cycle after reset, three times back to back -> grant order fetch, data, fetch.
REQ-030 SHALL test misaligned: d_addr=0x3, size=10 -> no m_en, d_err=1 and d_valid 1 cycle after gnt.
REQ-031 SHALL test timeout: TIMEOUT=4, m_ready held 0 -> 4 BUSY cycles, then if_err=1, if_rdata=0; next request serviced normally.
REQ-032 SHALL test reset mid-BUSY: reset low in second BUSY cycle -> m_en=0 immediately, no valid pulse, IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, access
// size codes, requester IDs and the alignment legality rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Fetches are presented as word accesses, so one rule covers both requesters.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic ill;
    case (size)
      SZ_BYTE: ill = 1'b0;
      SZ_HALF: ill = lane[0];
      SZ_WORD: ill = (lane != 2'b00);
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, store-data replication and
// right-aligned, sign/zero-extended load data.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    // Legal halves have lane[0]=0, so the same shift serves both sub-word sizes.
    shifted   = rdata_in >> {lane, 3'b000};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter in front of a single-port
// word memory with per-transaction timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_signed,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  state_e      state_q, state_d;
  req_id_e     owner_q, owner_d, last_q, last_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, sign_q, sign_d, gnt_q, gnt_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  req_id_e     pick;
  logic [31:0] pick_addr;
  logic [1:0]  pick_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        busy, resp;

  mem_lane_align u_align (
    .size      (size_q),
    .lane      (addr_q[1:0]),
    .sign_ext  (sign_q),
    .wdata_in  (wdata_q),
    .rdata_in  (m_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt_d   = 1'b0;

    // Data wins when alone, or on a tie when fetch was served last.
    pick      = REQ_IF;
    pick_addr = if_addr;
    pick_size = SZ_WORD;
    if (d_req && (!if_req || last_q == REQ_IF)) begin
      pick      = REQ_D;
      pick_addr = d_addr;
      pick_size = d_size;
    end

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          owner_d = pick;
          last_d  = pick;
          gnt_d   = 1'b1;
          addr_d  = pick_addr;
          size_d  = pick_size;
          we_d    = (pick == REQ_D) & d_we;
          sign_d  = (pick == REQ_D) & d_signed;
          wdata_d = (pick == REQ_D) ? d_wdata : '0;
          cnt_d   = '0;
          rdata_d = '0;
          if (is_illegal(pick_size, pick_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
            err_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (m_ready) begin
          state_d = ST_RESP;
          rdata_d = we_q ? '0 : lane_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IF;
      last_q  <= REQ_D;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs decode straight from flops, so an asynchronous reset clears them at once.
  assign busy     = (state_q == ST_BUSY);
  assign resp     = (state_q == ST_RESP);

  assign if_gnt   = gnt_q & (owner_q == REQ_IF);
  assign d_gnt    = gnt_q & (owner_q == REQ_D);
  assign if_valid = resp & (owner_q == REQ_IF);
  assign d_valid  = resp & (owner_q == REQ_D);
  assign if_err   = if_valid & err_q;
  assign d_err    = d_valid & err_q;
  assign if_rdata = if_valid ? rdata_q : '0;
  assign d_rdata  = d_valid ? rdata_q : '0;

  assign m_en     = busy;
  assign m_we     = busy & we_q;
  assign m_addr   = busy ? addr_q[31:2] : '0;
  assign m_be     = busy ? lane_be : '0;
  assign m_wdata  = busy ? lane_wdata : '0;

endmodule
